// File: rtl/fa.sv
// Registered WIDTH-bit ripple full adder with selectable carry-in (external or
// fed back from the previous result) for bit- or word-serial addition.
module fa #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c0,
    input  logic             chain,
    input  logic             in_valid,
    output logic [WIDTH-1:0] s,
    output logic             Ca,
    output logic             ovf,
    output logic             out_valid
);

    // One full-adder cell: returns {carry_out, sum}.
    function automatic logic [1:0] fa_cell(input logic x, input logic y, input logic ci);
        return {(x & y) | (x & ci) | (y & ci), x ^ y ^ ci};
    endfunction

    logic [WIDTH-1:0] s_q, s_d;
    logic             ca_q, ca_d;
    logic             ovf_q, ovf_d;
    logic             vld_q, vld_d;
    logic             carry_q, carry_d;

    logic             cin_s;
    logic [WIDTH:0]   c_s;
    logic [WIDTH-1:0] sum_s;
    logic             ovf_s;

    // Carry-in select and ripple chain; c_s[0] is cin, so WIDTH=1 overflow uses cin.
    always_comb begin
        cin_s = chain ? carry_q : c0;
        c_s   = '0;
        sum_s = '0;
        c_s[0] = cin_s;
        for (int i = 0; i < WIDTH; i++) begin
            {c_s[i+1], sum_s[i]} = fa_cell(a[i], b[i], c_s[i]);
        end
        ovf_s = c_s[WIDTH] ^ c_s[WIDTH-1];
    end

    // Next-state: capture a new result on valid input, otherwise hold.
    always_comb begin
        s_d     = s_q;
        ca_d    = ca_q;
        ovf_d   = ovf_q;
        carry_d = carry_q;
        vld_d   = 1'b0;
        if (in_valid) begin
            s_d     = sum_s;
            ca_d    = c_s[WIDTH];
            ovf_d   = ovf_s;
            carry_d = c_s[WIDTH];
            vld_d   = 1'b1;
        end else begin
            vld_d   = 1'b0;
        end
    end

    // State registers; reset wins over an operation in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_q     <= '0;
            ca_q    <= 1'b0;
            ovf_q   <= 1'b0;
            carry_q <= 1'b0;
            vld_q   <= 1'b0;
        end else begin
            s_q     <= s_d;
            ca_q    <= ca_d;
            ovf_q   <= ovf_d;
            carry_q <= carry_d;
            vld_q   <= vld_d;
        end
    end

    assign s         = s_q;
    assign Ca        = ca_q;
    assign ovf       = ovf_q;
    assign out_valid = vld_q;

endmodule

// File: tb/tb_fa.sv
// Self-checking bench for fa: one WIDTH=1 and one WIDTH=4 instance against an
// arithmetic reference model (integer add, signed range check).
module tb_fa;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic [0:0] a1 = '0, b1 = '0;
    logic       c01 = 1'b0, ch1 = 1'b0, v1 = 1'b0;
    logic [0:0] s1;
    logic       ca1, ovf1, ov1;

    logic [3:0] a4 = '0, b4 = '0;
    logic       c04 = 1'b0, ch4 = 1'b0, v4 = 1'b0;
    logic [3:0] s4;
    logic       ca4, ovf4, ov4;

    int passed = 0;
    int total  = 0;

    // Reference model state, index 0 = WIDTH 1, index 1 = WIDTH 4
    int m_s[2], m_ca[2], m_ovf[2], m_vld[2], m_carry[2];

    always #5 clk = ~clk;

    fa #(.WIDTH(1)) u_fa1 (
        .clk(clk), .rst(rst), .a(a1), .b(b1), .c0(c01), .chain(ch1),
        .in_valid(v1), .s(s1), .Ca(ca1), .ovf(ovf1), .out_valid(ov1)
    );

    fa #(.WIDTH(4)) u_fa4 (
        .clk(clk), .rst(rst), .a(a4), .b(b4), .c0(c04), .chain(ch4),
        .in_valid(v4), .s(s4), .Ca(ca4), .ovf(ovf4), .out_valid(ov4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic check_dut(input int idx, input string tag);
        if (idx == 0) begin
            chk({tag, ".s1"},   32'(s1),   32'(m_s[0]));
            chk({tag, ".ca1"},  32'(ca1),  32'(m_ca[0]));
            chk({tag, ".ovf1"}, 32'(ovf1), 32'(m_ovf[0]));
            chk({tag, ".ov1"},  32'(ov1),  32'(m_vld[0]));
        end else begin
            chk({tag, ".s4"},   32'(s4),   32'(m_s[1]));
            chk({tag, ".ca4"},  32'(ca4),  32'(m_ca[1]));
            chk({tag, ".ovf4"}, 32'(ovf4), 32'(m_ovf[1]));
            chk({tag, ".ov4"},  32'(ov4),  32'(m_vld[1]));
        end
    endtask

    // Expected result of one cycle on instance of width w
    task automatic model(input int idx, input int w, input int av, input int bv,
                         input int c0v, input int chv, input int vld);
        int md, cin, tot, sa, sb, ssum;
        md = 1 << w;
        if (vld != 0) begin
            cin  = (chv != 0) ? m_carry[idx] : c0v;
            tot  = av + bv + cin;
            sa   = (av >= md / 2) ? av - md : av;
            sb   = (bv >= md / 2) ? bv - md : bv;
            ssum = sa + sb + cin;
            m_s[idx]     = tot % md;
            m_ca[idx]    = (tot >= md) ? 1 : 0;
            m_ovf[idx]   = (ssum < -(md / 2) || ssum > md / 2 - 1) ? 1 : 0;
            m_carry[idx] = m_ca[idx];
            m_vld[idx]   = 1;
        end else begin
            m_vld[idx] = 0;
        end
    endtask

    task automatic op(input int w, input int av, input int bv, input int c0v,
                      input int chv, input int vld, input string tag);
        int idx;
        idx = (w == 1) ? 0 : 1;
        v1 = 1'b0;
        v4 = 1'b0;
        if (idx == 0) begin
            a1 = av[0:0]; b1 = bv[0:0]; c01 = c0v[0]; ch1 = chv[0]; v1 = vld[0];
        end else begin
            a4 = av[3:0]; b4 = bv[3:0]; c04 = c0v[0]; ch4 = chv[0]; v4 = vld[0];
        end
        model(idx, w, av, bv, c0v, chv, vld);
        model(1 - idx, 1, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        check_dut(idx, tag);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        v1 = 1'b1; a1 = 1'b1; b1 = 1'b1;
        v4 = 1'b1; a4 = 4'd15; b4 = 4'd15;
        for (int i = 0; i < 2; i++) begin
            m_s[i] = 0; m_ca[i] = 0; m_ovf[i] = 0; m_vld[i] = 0; m_carry[i] = 0;
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        v1 = 1'b0;
        v4 = 1'b0;
        check_dut(0, tag);
        check_dut(1, tag);
    endtask

    initial begin
        int av, bv, c0v, chv, vld;

        @(posedge clk);
        do_reset("reset");

        // WIDTH=1 basic pair
        op(1, 1, 1, 0, 0, 1, "basic_11");
        op(1, 1, 0, 0, 0, 1, "basic_10");

        // WIDTH=1 exhaustive
        for (int k = 0; k < 8; k++) begin
            op(1, (k >> 2) & 1, (k >> 1) & 1, k & 1, 0, 1, $sformatf("exh%0d", k));
        end

        // WIDTH=4 overflow corners
        op(4, 7, 1, 0, 0, 1, "w4_7p1");
        op(4, 15, 1, 0, 0, 1, "w4_15p1");
        op(4, 8, 8, 1, 0, 1, "w4_8p8c");

        // Serial 3+1 LSB first
        op(1, 1, 1, 0, 0, 1, "ser0");
        op(1, 1, 0, 0, 1, 1, "ser1");
        op(1, 0, 0, 0, 1, 1, "ser2");

        // Hold for three idle cycles
        op(4, 9, 9, 0, 0, 1, "pre_hold");
        for (int k = 0; k < 3; k++) begin
            op(4, 3, 3, 1, 0, 0, $sformatf("hold%0d", k));
        end

        // Reset with carry pending, then chained word uses carry-in 0
        op(1, 1, 1, 0, 0, 1, "carry_set");
        op(4, 15, 15, 0, 0, 1, "carry_set4");
        do_reset("reset_op");
        op(1, 1, 0, 1, 1, 1, "chain_after_rst");
        op(4, 15, 0, 1, 1, 1, "chain_after_rst4");

        // Random ops with random chaining and gaps
        for (int k = 0; k < 120; k++) begin
            av  = int'($urandom_range(15, 0));
            bv  = int'($urandom_range(15, 0));
            c0v = int'($urandom_range(1, 0));
            chv = int'($urandom_range(1, 0));
            vld = ($urandom_range(3, 0) != 0) ? 1 : 0;
            if (k % 2 == 0) begin
                op(1, av & 1, bv & 1, c0v, chv, vld, $sformatf("rnd1_%0d", k));
            end else begin
                op(4, av, bv, c0v, chv, vld, $sformatf("rnd4_%0d", k));
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
